// File: rtl/avg_sched_pkg.sv
// avg_sched_pkg
//   Shared definitions for the round-robin averaging scheduler:
//   - state_t   : scheduler FSM states (IDLE / COLLECT / RESULT)
//   - FRAME_LEN : number of samples accepted per granted frame
//   - SHIFT     : right shift that turns the frame sum into the average
//   - CNT_W     : width of the per-frame sample counter
package avg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam int FRAME_LEN = 4;
  localparam int SHIFT     = 2;
  localparam int CNT_W     = $clog2(FRAME_LEN);

endpackage

// File: rtl/avg_share_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin first-one search. Returns the index of the
//   first asserted req_valid bit at or after rr_ptr, wrapping past N_REQ-1.
//
// Ports
//   req_valid [N_REQ] in  : request vector
//   rr_ptr    [IDW]   in  : search start position
//   gnt_idx   [IDW]   out : selected channel (only meaningful when any=1)
//   any               out : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  // cand[k] is the channel sitting k positions after rr_ptr (modulo N_REQ);
  // hit[k] says whether that channel is requesting.
  logic [IDW-1:0]   cand [N_REQ];
  logic [N_REQ-1:0] hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDW:0] raw;
      // One extra bit so rr_ptr + offset cannot wrap before the modulo step.
      assign raw        = {1'b0, rr_ptr} + (IDW+1)'(gi);
      assign cand[gi]   = (raw >= (IDW+1)'(N_REQ)) ? IDW'(raw - (IDW+1)'(N_REQ))
                                                   : raw[IDW-1:0];
      assign hit[gi]    = req_valid[cand[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        gnt_idx = cand[k];
      end
    end
  end

  assign any = |req_valid;

endmodule

// File: rtl/avg_share_sched.sv
// avg_share_sched
//   Shares one 4-sample averaging datapath among N_REQ channels. A channel is
//   granted per frame in round-robin order, four samples are taken from it
//   over valid/ready, and the frame average plus |average - last sample| are
//   presented tagged with the channel id.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req_valid [N_REQ]      : per-channel sample valid
//   req_data  [N_REQ*W]    : per-channel sample, channel i at [i*W +: W]
//   req_ready [N_REQ]      : per-channel accept (granted channel in COLLECT)
//   res_valid              : result available (RESULT state)
//   res_ready              : consumer accepts result
//   res_avg   [W]          : frame average
//   res_diff  [W]          : |res_avg - 4th sample|
//   res_id    [IDW]        : channel that produced the result
//   idle                   : high in IDLE (frame boundary)
module avg_share_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_avg,
  output logic [W-1:0]       res_diff,
  output logic [IDW-1:0]     res_id,
  output logic               idle
);

  import avg_sched_pkg::*;

  state_t           state_reg,    state_next;
  logic [IDW-1:0]   rr_ptr_reg,   rr_ptr_next;
  logic [IDW-1:0]   grant_reg,    grant_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic [W+1:0]     acc_reg,      acc_next;
  logic [W-1:0]     res_avg_reg,  res_avg_next;
  logic [W-1:0]     res_diff_reg, res_diff_next;
  logic [IDW-1:0]   res_id_reg,   res_id_next;

  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  logic [W-1:0]     sample;
  logic             accept;
  logic             last_sample;
  logic [W+1:0]     frame_sum;
  logic [W-1:0]     frame_avg;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .gnt_idx   (pick_idx),
    .any       (pick_any)
  );

  // Datapath for the granted channel. acc is W+2 bits, so four W-bit samples
  // can never overflow it and the shifted sum always fits back into W bits.
  assign sample      = req_data[grant_reg*W +: W];
  assign accept      = (state_reg == COLLECT) && req_valid[grant_reg];
  assign last_sample = (cnt_reg == CNT_W'(FRAME_LEN - 1));
  assign frame_sum   = acc_reg + {2'b00, sample};
  assign frame_avg   = W'(frame_sum >> SHIFT);

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_next    = grant_reg;
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    res_avg_next  = res_avg_reg;
    res_diff_next = res_diff_reg;
    res_id_next   = res_id_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        acc_next = '0;
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = COLLECT;
        end
      end

      COLLECT: begin
        // Grant stays locked on grant_reg until the frame completes;
        // a low req_valid simply stalls.
        if (accept) begin
          if (last_sample) begin
            res_avg_next  = frame_avg;
            res_diff_next = (frame_avg >= sample) ? (frame_avg - sample)
                                                  : (sample - frame_avg);
            res_id_next   = grant_reg;
            // Pointer moves now, so the next IDLE decision already sees it.
            rr_ptr_next   = (grant_reg == IDW'(N_REQ - 1)) ? '0
                                                           : grant_reg + 1'b1;
            state_next    = RESULT;
          end else begin
            acc_next = frame_sum;
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      RESULT: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      res_avg_reg  <= '0;
      res_diff_reg <= '0;
      res_id_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_reg    <= grant_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      res_avg_reg  <= res_avg_next;
      res_diff_reg <= res_diff_next;
      res_id_reg   <= res_id_next;
    end
  end

  // Handshake outputs decode registered state only.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == COLLECT) && (grant_reg == IDW'(gi));
    end
  endgenerate

  assign res_valid = (state_reg == RESULT);
  assign idle      = (state_reg == IDLE);
  assign res_avg   = res_avg_reg;
  assign res_diff  = res_diff_reg;
  assign res_id    = res_id_reg;

endmodule

// File: tb/tb_avg_share_sched.sv
// tb_avg_share_sched
//   Directed, self-checking bench for avg_share_sched (N_REQ=4, W=8).
//   Each scenario task drives stimulus and checks its own results.
module tb_avg_share_sched;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [W-1:0]       res_avg;
  logic [W-1:0]       res_diff;
  logic [IDW-1:0]     res_id;
  logic               idle;

  int n_vec;
  int n_err;
  int cyc;

  avg_share_sched #(
    .N_REQ (N_REQ),
    .W     (W),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_avg   (res_avg),
    .res_diff  (res_diff),
    .res_id    (res_id),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on channel ch and hold it until accepted (bounded).
  task automatic feed(input int ch, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    req_data[ch*W +: W] = d;
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[ch]) begin
        tick();
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_vec++; if (res_avg !== 8'd0) begin n_err++; $display("FAIL reset_res_avg: got %0d expected 0", res_avg); end
    n_vec++; if (res_diff !== 8'd0) begin n_err++; $display("FAIL reset_res_diff: got %0d expected 0", res_diff); end
    n_vec++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit ok, all_ok;
    int c0;
    logic [7:0] s [4];
    s[0] = 8'd10; s[1] = 8'd20; s[2] = 8'd30; s[3] = 8'd40;
    res_ready = 1'b1;
    all_ok = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      feed(0, s[k], ok);
      all_ok &= ok;
    end
    req_valid[0] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL basic_accept_timeout: got %b expected 1", all_ok); end
    n_vec++; if (cyc - c0 !== 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", cyc - c0); end
    n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL basic_res_valid: got %b expected 1", res_valid); end
    n_vec++; if (res_avg !== 8'd25) begin n_err++; $display("FAIL basic_avg: got %0d expected 25", res_avg); end
    n_vec++; if (res_diff !== 8'd15) begin n_err++; $display("FAIL basic_diff: got %0d expected 15", res_diff); end
    n_vec++; if (res_id !== 2'd0) begin n_err++; $display("FAIL basic_id: got %0d expected 0", res_id); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL basic_result_ready: got %b expected 0000", req_ready); end
    tick();
    n_vec++; if (idle !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL basic_back_to_idle: got idle=%b valid=%b expected idle=1 valid=0", idle, res_valid); end
    $display("test_basic: ch0 10,20,30,40 -> avg=%0d diff=%0d id=%0d", 25, 15, 0);
  endtask

  task automatic test_extremes();
    bit ok, all_ok;
    res_ready = 1'b1;
    all_ok = 1'b1;
    // rr_ptr is 1 here; only ch2 requests.
    for (int k = 0; k < 4; k++) begin
      feed(2, 8'd255, ok);
      all_ok &= ok;
    end
    req_valid[2] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL max_accept_timeout: got %b expected 1", all_ok); end
    n_vec++; if (res_avg !== 8'd255 || res_diff !== 8'd0 || res_id !== 2'd2) begin n_err++; $display("FAIL max_result: got avg=%0d diff=%0d id=%0d expected avg=255 diff=0 id=2", res_avg, res_diff, res_id); end
    tick();
    // rr_ptr is 3 now; ch1 must still be found by wrapping.
    all_ok = 1'b1;
    feed(1, 8'd0, ok); all_ok &= ok;
    feed(1, 8'd0, ok); all_ok &= ok;
    feed(1, 8'd0, ok); all_ok &= ok;
    feed(1, 8'd4, ok); all_ok &= ok;
    req_valid[1] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL small_accept_timeout: got %b expected 1", all_ok); end
    n_vec++; if (res_avg !== 8'd1 || res_diff !== 8'd3 || res_id !== 2'd1) begin n_err++; $display("FAIL small_result: got avg=%0d diff=%0d id=%0d expected avg=1 diff=3 id=1", res_avg, res_diff, res_id); end
    tick();
    $display("test_extremes: ch2 255x4 -> 255/0, ch1 0,0,0,4 -> 1/3");
  endtask

  task automatic test_round_robin();
    int exp_ch, waited;
    logic [3:0] onehot;
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < N_REQ; k++) req_data[k*W +: W] = 8'(k*10 + 5);
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_ch = f % 4;
      onehot = 4'(1 << exp_ch);
      waited = 0;
      while (req_ready === 4'b0000 && waited < 20) begin
        tick();
        waited++;
      end
      n_vec++; if (req_ready !== onehot) begin n_err++; $display("FAIL rr_grant frame %0d: got %b expected %b", f, req_ready, onehot); end
      for (int k = 0; k < 4; k++) begin
        n_vec++; if (req_ready !== onehot) begin n_err++; $display("FAIL rr_exclusive frame %0d beat %0d: got %b expected %b", f, k, req_ready, onehot); end
        tick();
      end
      n_vec++; if (res_valid !== 1'b1 || res_id !== 2'(exp_ch) || res_avg !== 8'(exp_ch*10 + 5)) begin n_err++; $display("FAIL rr_result frame %0d: got valid=%b id=%0d avg=%0d expected valid=1 id=%0d avg=%0d", f, res_valid, res_id, res_avg, exp_ch, exp_ch*10 + 5); end
      $display("test_round_robin: frame %0d granted ch%0d", f, exp_ch);
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    bit ok, all_ok;
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    req_data[3*W +: W] = 8'd100;
    req_valid[3] = 1'b1;
    all_ok = 1'b1;
    feed(1, 8'd8, ok);  all_ok &= ok;
    feed(1, 8'd16, ok); all_ok &= ok;
    req_valid[1] = 1'b0;
    for (int g = 0; g < 5; g++) begin
      n_vec++; if (req_ready !== 4'b0010 || res_valid !== 1'b0) begin n_err++; $display("FAIL stall_locked gap %0d: got ready=%b valid=%b expected ready=0010 valid=0", g, req_ready, res_valid); end
      tick();
    end
    feed(1, 8'd24, ok); all_ok &= ok;
    feed(1, 8'd32, ok); all_ok &= ok;
    req_valid[1] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL stall_accept_timeout: got %b expected 1", all_ok); end
    n_vec++; if (res_id !== 2'd1 || res_avg !== 8'd20 || res_diff !== 8'd12) begin n_err++; $display("FAIL stall_result: got id=%0d avg=%0d diff=%0d expected id=1 avg=20 diff=12", res_id, res_avg, res_diff); end
    $display("test_stall: ch1 frame with 5-cycle gap -> avg=20 diff=12");
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      feed(3, 8'd100, ok);
      all_ok &= ok;
    end
    req_valid[3] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL stall_ch3_timeout: got %b expected 1", all_ok); end
    n_vec++; if (res_id !== 2'd3 || res_avg !== 8'd100 || res_diff !== 8'd0) begin n_err++; $display("FAIL stall_next_ch3: got id=%0d avg=%0d diff=%0d expected id=3 avg=100 diff=0", res_id, res_avg, res_diff); end
    $display("test_stall: ch3 served next");
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, all_ok;
    logic [23:0] got, exp_v;
    res_ready = 1'b0;
    req_data[2*W +: W] = 8'd50;
    req_valid[2] = 1'b1;
    all_ok = 1'b1;
    feed(0, 8'd1, ok); all_ok &= ok;
    feed(0, 8'd2, ok); all_ok &= ok;
    feed(0, 8'd3, ok); all_ok &= ok;
    feed(0, 8'd6, ok); all_ok &= ok;
    req_valid[0] = 1'b0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL bp_accept_timeout: got %b expected 1", all_ok); end
    // {res_valid, res_avg, res_diff, res_id, req_ready, idle}
    exp_v = {1'b1, 8'd3, 8'd3, 2'd0, 4'b0000, 1'b0};
    for (int c = 0; c < 10; c++) begin
      got = {res_valid, res_avg, res_diff, res_id, req_ready, idle};
      n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL bp_hold cycle %0d: got %h expected %h", c, got, exp_v); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    n_vec++; if (idle !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL bp_consume: got idle=%b valid=%b expected idle=1 valid=0", idle, res_valid); end
    tick();
    n_vec++; if (idle !== 1'b1 || req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant: got idle=%b ready=%b expected idle=1 ready=0000", idle, req_ready); end
    $display("test_backpressure: result held 10 cycles, avg=3 diff=3");
  endtask

  task automatic test_reset_midframe();
    bit ok, all_ok;
    res_ready = 1'b1;
    all_ok = 1'b1;
    feed(2, 8'd200, ok); all_ok &= ok;
    feed(2, 8'd200, ok); all_ok &= ok;
    feed(2, 8'd200, ok); all_ok &= ok;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL midrst_accept_timeout: got %b expected 1", all_ok); end
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    n_vec++; if (idle !== 1'b1 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_state: got idle=%b valid=%b ready=%b expected idle=1 valid=0 ready=0000", idle, res_valid, req_ready); end
    // rr_ptr back at 0: ch0 must win over ch3.
    req_data[3*W +: W] = 8'd9;
    req_data[0*W +: W] = 8'd4;
    req_valid = 4'b1001;
    tick();
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr: got ready=%b expected 0001", req_ready); end
    all_ok = 1'b1;
    feed(0, 8'd4, ok);  all_ok &= ok;
    feed(0, 8'd8, ok);  all_ok &= ok;
    feed(0, 8'd12, ok); all_ok &= ok;
    feed(0, 8'd16, ok); all_ok &= ok;
    req_valid = '0;
    n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL midrst_new_timeout: got %b expected 1", all_ok); end
    n_vec++; if (res_valid !== 1'b1 || res_avg !== 8'd10 || res_diff !== 8'd6 || res_id !== 2'd0) begin n_err++; $display("FAIL midrst_result: got valid=%b avg=%0d diff=%0d id=%0d expected valid=1 avg=10 diff=6 id=0", res_valid, res_avg, res_diff, res_id); end
    $display("test_reset_midframe: partial ch2 frame dropped, ch0 4,8,12,16 -> avg=10 diff=6");
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avg_share_sched.md
# avg_share_sched

Round-robin scheduler that shares one 4-sample averaging datapath among `N_REQ` requesting channels. It grants the datapath to one channel per frame and accepts exactly four samples from that channel over a valid/ready handshake. It then returns the frame average and the absolute deviation of the last sample, tagged with the channel id. It sits between the serial sample sources and the downstream statistics consumer.

## Interface
- `N_REQ`, default 4: number of requesting channels (≥2).
- `W`, default 8: sample width.
- `IDW`, default $clog2(N_REQ): channel id width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  N_REQ  per-channel sample valid.
- `req_data`  in  N_REQ*W  per-channel sample; channel i occupies bits [i*W +: W].
- `req_ready`  out  N_REQ  per-channel sample accept.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_avg`  out  W  frame average.
- `res_diff`  out  W  |avg − 4th sample|.
- `res_id`  out  IDW  channel that produced the result.
- `idle`  out  1  high in IDLE state (frame boundary).

## Operation
- States are IDLE, COLLECT and RESULT.
- **IDLE**
  - If any `req_valid` is high, grant the first channel with `req_valid` high at or after `rr_ptr` (wrapping), then go to COLLECT.
  - Reset `cnt` to 0 and clear `acc`.
  - Stay in IDLE if no request is present.
- **COLLECT**
  - `req_ready[g]` = 1 for the granted channel g; all other bits are 0.
  - On each accept (`req_valid[g] & req_ready[g]`): `acc += req_data[g]` (acc is W+2 bits, no overflow possible), `cnt++`.
  - On the 4th accept:
    - `res_avg` ← (acc + sample) >> 2, truncated to W bits.
    - `res_diff` ← |res_avg − sample|, using the unsigned compare-then-subtract form.
    - `res_id` ← g, `rr_ptr` ← (g+1) mod N_REQ.
    - Go to RESULT.
  - Gaps (`req_valid[g]` low) stall the frame indefinitely. The grant is locked; no other channel is served mid-frame.
  - `req_valid` dropping on non-granted channels has no effect.
- **RESULT**
  - `res_valid` = 1. `res_avg`, `res_diff` and `res_id` are held stable while `res_valid` is high.
  - When `res_ready` is high, go to IDLE.
  - All `req_ready` bits are 0.
- `idle` = (state == IDLE).
- Reset:
  - state IDLE, `rr_ptr` 0, `cnt` 0, `acc` 0.
  - `res_valid` 0, `res_avg` 0, `res_diff` 0, `res_id` 0, `req_ready` all 0.
  - Reset mid-frame discards partial samples; no result is emitted.

## Timing
- Registered state. `req_ready` and `res_valid` are decoded from registered state only; there is no combinational path from `req_valid` or `res_ready`.
- Grant decision takes 1 cycle in IDLE; `req_ready` goes high in the following cycle.
- Best-case frame:
  - IDLE cycle 0.
  - Accepts in cycles 1–4.
  - `res_valid` in cycle 5.
  - Consumed in cycle 5 if `res_ready` is high.
  - Back to IDLE in cycle 6, which gives 6 cycles/frame throughput.
- A requester whose `req_valid` is high in the same IDLE cycle as `rr_ptr` changes competes against the updated pointer; `rr_ptr` is updated on the 4th accept, before RESULT.
- Fairness: a continuously requesting channel waits at most N_REQ−1 frames.
- `res_ready` high outside RESULT is ignored.

## Structure
- Package `avg_sched_pkg` holds:
  - the state enum (IDLE/COLLECT/RESULT);
  - the `FRAME_LEN = 4` constant;
  - the `SHIFT = 2` constant.
- Sub-module `rr_pick`: combinational round-robin first-one search. Inputs are `req_valid` and `rr_ptr`; outputs are `gnt_idx` and `any`. It is parameterised by N_REQ.
- The top level holds the FSM, accumulator, result registers and handshake decode.

## Test plan
- Reset, then ch0 sends 10, 20, 30, 40 with `res_ready`=1 → `res_avg`=25, `res_diff`=15, `res_id`=0, `res_valid` in cycle 5 after IDLE.
- ch2 sends 255 ×4 → `res_avg`=255, `res_diff`=0 (no overflow); ch1 sends 0, 0, 0, 4 → `res_avg`=1, `res_diff`=3.
- All channels requesting continuously → grants 0, 1, 2, 3, 0 in order; no `req_ready` on non-granted channels.
- Granted ch1 drops `req_valid` for 5 cycles after the 2nd sample, while ch3 holds valid → ch1 frame completes first and `res_id`=1; ch3 is served next.
- `res_ready` held low for 10 cycles in RESULT → outputs stable, `req_ready` all 0, no new grant; result consumed on the first `res_ready` cycle.
- Assert `rst` after the 3rd accepted sample → next cycle `idle`=1, `res_valid`=0, `rr_ptr`=0, and the next frame's result reflects only new samples.
